prbs31_128bit_chk: RTL and testbench
====================================

# prbs31_128bit_chk

Self-synchronising checker for the 128-bit-per-cycle PRBS31 / count data streams produced by the DDR3 example-design traffic generator. It sits on the read-data path after the DDR controller, locks onto the incoming pattern without a shared seed, and then free-runs its own prediction. It reports lock status, per-word error pulses and saturating word/bit error counters for the test status registers.

## Interface
- LOCK_CNT, 4: consecutive matching words needed in SEARCH to declare lock (1..15).
- UNLOCK_CNT, 4: consecutive erroneous words in LOCKED that force SEARCH (1..15).
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- clk_en  in  1  global enable; when low, all state holds and inputs are ignored.
- cnt_mode  in  1  0: PRBS31 pattern, 1: incrementing 128-bit count pattern.
- din  in  128  received data word.
- din_vld  in  1  din valid; words with din_vld=0 are ignored and do not advance the prediction.
- clr_cnt  in  1  synchronous clear of error counters and lost_lock.
- locked  out  1  checker is in LOCKED.
- err_flag  out  1  one-cycle pulse: the last accepted word in LOCKED mismatched.
- err_word_cnt  out  32  saturating count of erroneous words while locked.
- err_bit_cnt  out  32  saturating count of erroneous bits while locked.
- lost_lock  out  1  sticky: a LOCKED→SEARCH transition has occurred.

## Operation
- Accepted word: clk_en=1 and din_vld=1 at a rising edge.
- pred(w) = prbs31_next128(w) when cnt_mode=0, i.e. the generator's next-word function (x^31+x^28+1, XNOR form, using only bits [30:0] of w). pred(w) = w+1 mod 2^128 when cnt_mode=1.
- States: SEARCH (reset state) and LOCKED. Registers: prev[127:0], prev_vld, ref[127:0], match_run[3:0], miss_run[3:0].
- SEARCH, on each accepted word:
  - If prev_vld=0, load prev<=din and prev_vld<=1. Nothing else changes.
  - Otherwise, match when din==pred(prev). In PRBS mode, a word with din[30:0] all ones is never a match, because it is the XNOR lockup state.
  - On a match, match_run increments; otherwise match_run clears. prev<=din in both cases.
  - When a match brings match_run to LOCK_CNT: go to LOCKED, ref<=din, miss_run<=0.
- LOCKED, on each accepted word:
  - Compare din against pred(ref), then ref<=pred(ref). The prediction free-runs, so a bit error never propagates into later predictions.
  - On a mismatch: err_flag pulses, and the counters add 1 word and popcount(din^pred(ref)) bits.
  - miss_run increments on a mismatch and clears on a match.
  - When miss_run reaches UNLOCK_CNT: go to SEARCH, prev<=din, prev_vld<=1, match_run<=0, lost_lock<=1.
- A change of cnt_mode between consecutive accepted words forces SEARCH with prev_vld<=0. lost_lock is set if the checker was LOCKED.
- Counters saturate at 0xFFFF_FFFF.
- clr_cnt (when clk_en=1) zeroes both counters and lost_lock. It wins over an increment or set landing in the same cycle. It does not affect lock state.
- Reset values: state SEARCH, all registers 0, locked=0, err_flag=0, counters 0, lost_lock=0. Reset mid-stream discards lock immediately (asynchronous).

## Timing
- locked changes at the edge that accepts the deciding word (it is a registered state decode).
- err_flag is registered and high during the cycle after the accepting edge.
- Bit popcount is registered at the accepting edge. Counters update one edge later, so counter latency is 2 cycles after the word.
- With clk_en low, the pending counter update stage also holds.
- Full throughput: one word per cycle, no back-pressure.

## Structure
- Shared package prbs31_pkg holds:
  - function prbs31_next128, also used by the generator;
  - the state encoding (SEARCH=1'b0, LOCKED=1'b1);
  - the counter width constant ERR_CNT_W=32.
- One sub-module: popcnt128, a registered 128-bit population count (8-bit result, 1-cycle latency).

## Test plan
- Clean PRBS stream from the generator (PRBS_INIT=0), din_vld=1 every cycle → locked=1 at the edge accepting the 5th word. Counters stay 0 over 10 000 words.
- Locked, flip din[0] and din[64] of one word → err_flag pulses once. err_word_cnt=1, err_bit_cnt=2. locked stays 1, and the next word is error-free.
- Locked, feed 4 consecutive all-zero words → counters 4 words / ~256 bits. locked=0 after the 4th, lost_lock=1. A clean stream relocks after 5 more words.
- Constant all-ones din in PRBS mode → locked never rises over 100 words.
- cnt_mode=1, din counting from 0xFFFF…FFFC with gaps in din_vld → locks after 5 valid words across the 2^128 wrap, no errors. Toggling cnt_mode → locked=0 next cycle.
- Preload err_word_cnt near saturation via 0xFFFF_FFFF forced errors → count stays 0xFFFF_FFFF. clr_cnt together with an error → counters 0.

Source files
------------

// File: rtl/prbs31_pkg.sv
// Shared PRBS31 definitions for the DDR3 traffic generator and read-data checker.
// Latency: n/a (types, constants and a combinational next-word function).
// Backpressure: n/a.
package prbs31_pkg;

    // Checker lock state; SEARCH is the reset state.
    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    localparam int ERR_CNT_W = 32;

    // Advance the x^31+x^28+1 XNOR LFSR by 128 steps. The seed is the low 31
    // bits of the previous word. The first generated bit lands in bit 127, so
    // the final LFSR state is the low 31 bits of the returned word.
    function automatic logic [127:0] prbs31_next128(input logic [30:0] seed);
        logic [30:0]  s;
        logic         b;
        logic [127:0] o;
        s = seed;
        o = '0;
        for (int i = 0; i < 128; i++) begin
            b          = ~(s[30] ^ s[27]);
            s          = {s[29:0], b};
            o[127 - i] = b;
        end
        return o;
    endfunction

endpackage

// File: rtl/prbs31_128bit_chk_popcnt128.sv
// Registered population count of a 128-bit vector.
// Latency: 1 cycle from din to cnt_q.
// Backpressure: none; en low holds the result.
module popcnt128 (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic [127:0] din,
    output logic [7:0]   cnt
);

    logic [7:0] cnt_d;
    logic [7:0] cnt_q;

    // Adder tree left to synthesis; a straight accumulation reads clearest.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < 128; i++) begin
            cnt_d = cnt_d + 8'(din[i]);
        end
    end

    // Capture the count whenever the pipeline advances.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/prbs31_128bit_chk.sv
// Self-synchronising PRBS31 / count pattern checker, 128 bits per cycle.
// Latency: locked/err_flag 1 cycle after the word, error counters 2 cycles.
// Backpressure: none; accepts a word every cycle din_vld=1 and clk_en=1.
module prbs31_128bit_chk
    import prbs31_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clk_en,
    input  logic                 cnt_mode,
    input  logic [127:0]         din,
    input  logic                 din_vld,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_word_cnt,
    output logic [ERR_CNT_W-1:0] err_bit_cnt,
    output logic                 lost_lock
);

    localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

    chk_state_e           state_q, state_d;
    logic [127:0]         prev_q, prev_d;
    logic                 prev_vld_q, prev_vld_d;
    logic [127:0]         ref_q, ref_d;
    logic [3:0]           match_run_q, match_run_d;
    logic [3:0]           miss_run_q, miss_run_d;
    logic                 mode_q, mode_d;
    logic                 err_flag_q, err_flag_d;
    logic                 lost_set;
    logic [ERR_CNT_W-1:0] word_cnt_q, bit_cnt_q;
    logic                 lost_lock_q;

    logic                 accept;
    logic [127:0]         pred_prev, pred_ref, diff;
    logic                 lockup, srch_match, lk_mis, mode_chg;
    logic [7:0]           pop_cnt;
    logic [ERR_CNT_W:0]   word_sum, bit_sum;

    assign accept = clk_en & din_vld;

    // Predictions from the search history and from the free-running reference.
    always_comb begin
        pred_prev  = cnt_mode ? prev_q + 128'd1 : prbs31_next128(prev_q[30:0]);
        pred_ref   = cnt_mode ? ref_q + 128'd1  : prbs31_next128(ref_q[30:0]);
        diff       = din ^ pred_ref;
        lk_mis     = |diff;
        // All-ones low bits reproduce themselves under XNOR feedback, so a stuck
        // bus would otherwise look like a valid PRBS stream.
        lockup     = ~cnt_mode & (&din[30:0]);
        srch_match = (din == pred_prev) & ~lockup;
        // Only a word that follows real history can see a mode change.
        mode_chg   = ((state_q == LOCKED) | prev_vld_q) & (cnt_mode != mode_q);
    end

    // Search/lock next-state decisions for one accepted word.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        ref_d       = ref_q;
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
        mode_d      = mode_q;
        err_flag_d  = 1'b0;
        lost_set    = 1'b0;
        if (accept) begin
            mode_d = cnt_mode;
            if (mode_chg) begin
                state_d     = SEARCH;
                prev_vld_d  = 1'b0;
                match_run_d = '0;
                lost_set    = (state_q == LOCKED);
            end else if (state_q == SEARCH) begin
                prev_d     = din;
                prev_vld_d = 1'b1;
                if (prev_vld_q) begin
                    if (srch_match) begin
                        match_run_d = match_run_q + 4'd1;
                        if (match_run_d == LOCK_C) begin
                            state_d    = LOCKED;
                            ref_d      = din;
                            miss_run_d = '0;
                        end
                    end else begin
                        match_run_d = '0;
                    end
                end
            end else begin
                ref_d = pred_ref;
                if (lk_mis) begin
                    err_flag_d = 1'b1;
                    miss_run_d = miss_run_q + 4'd1;
                    if (miss_run_d == UNLOCK_C) begin
                        state_d     = SEARCH;
                        prev_d      = din;
                        prev_vld_d  = 1'b1;
                        match_run_d = '0;
                        lost_set    = 1'b1;
                    end
                end else begin
                    miss_run_d = '0;
                end
            end
        end
    end

    // Bit errors are only counted for mismatches found while locked.
    popcnt128 u_popcnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (clk_en),
        .din  (err_flag_d ? diff : 128'd0),
        .cnt  (pop_cnt)
    );

    // Lock state and prediction registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= SEARCH;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            ref_q       <= '0;
            match_run_q <= '0;
            miss_run_q  <= '0;
            mode_q      <= 1'b0;
            err_flag_q  <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            ref_q       <= ref_d;
            match_run_q <= match_run_d;
            miss_run_q  <= miss_run_d;
            mode_q      <= mode_d;
            err_flag_q  <= err_flag_d;
        end
    end

    assign word_sum = {1'b0, word_cnt_q} + (ERR_CNT_W + 1)'(1);
    assign bit_sum  = {1'b0, bit_cnt_q} + (ERR_CNT_W + 1)'(pop_cnt);

    // Saturating error counters, fed by the registered flag and popcount.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            lost_lock_q <= 1'b0;
        end else if (clk_en) begin
            if (clr_cnt) begin
                word_cnt_q  <= '0;
                bit_cnt_q   <= '0;
                lost_lock_q <= 1'b0;
            end else begin
                if (err_flag_q) begin
                    word_cnt_q <= word_sum[ERR_CNT_W] ? '1 : word_sum[ERR_CNT_W-1:0];
                    bit_cnt_q  <= bit_sum[ERR_CNT_W]  ? '1 : bit_sum[ERR_CNT_W-1:0];
                end
                if (lost_set) begin
                    lost_lock_q <= 1'b1;
                end
            end
        end
    end

    assign locked       = (state_q == LOCKED);
    assign err_flag     = err_flag_q;
    assign err_word_cnt = word_cnt_q;
    assign err_bit_cnt  = bit_cnt_q;
    assign lost_lock    = lost_lock_q;

endmodule

// File: tb/tb_prbs31_128bit_chk.sv
// Bench for prbs31_128bit_chk: scoreboarded lock/error-flag checks per word
// plus counter and sticky-status checks at the interesting points.
module tb_prbs31_128bit_chk;

    logic         clk;
    logic         rstn;
    logic         clk_en;
    logic         cnt_mode;
    logic [127:0] din;
    logic         din_vld;
    logic         clr_cnt;
    logic         locked;
    logic         err_flag;
    logic [31:0]  err_word_cnt;
    logic [31:0]  err_bit_cnt;
    logic         lost_lock;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic lk;
        logic ef;
    } exp_t;
    exp_t sbq[$];

    logic [30:0] gst;

    prbs31_128bit_chk #(.LOCK_CNT(4), .UNLOCK_CNT(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .clk_en       (clk_en),
        .cnt_mode     (cnt_mode),
        .din          (din),
        .din_vld      (din_vld),
        .clr_cnt      (clr_cnt),
        .locked       (locked),
        .err_flag     (err_flag),
        .err_word_cnt (err_word_cnt),
        .err_bit_cnt  (err_bit_cnt),
        .lost_lock    (lost_lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Serial model of the traffic generator: 128 LFSR shifts per word, first
    // bit shifted in ends up as the MSB.
    task automatic gen_word(output logic [127:0] w);
        logic b;
        w = '0;
        for (int i = 0; i < 128; i++) begin
            b   = ~(gst[30] ^ gst[27]);
            gst = {gst[29:0], b};
            w   = {w[126:0], b};
        end
    endtask

    task automatic step(input logic [127:0] d, input logic v, input logic en,
                        input logic exp_lk, input logic exp_ef);
        exp_t e;
        din     = d;
        din_vld = v;
        clk_en  = en;
        sbq.push_back('{lk: exp_lk, ef: exp_ef});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("locked", 128'(locked), 128'(e.lk));
        chk("err_flag", 128'(err_flag), 128'(e.ef));
    endtask

    task automatic do_reset();
        din_vld = 1'b0;
        clr_cnt = 1'b0;
        rstn    = 1'b0;
        #3;
        chk("rst_locked", 128'(locked), 128'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        logic [127:0] w;
        logic [127:0] c;
        int           bits;
        int           nv;

        rstn     = 1'b0;
        clk_en   = 1'b1;
        cnt_mode = 1'b0;
        din      = '0;
        din_vld  = 1'b0;
        clr_cnt  = 1'b0;
        gst      = '0;
        #12;
        chk("rst_err_flag", 128'(err_flag), 128'd0);
        chk("rst_word_cnt", 128'(err_word_cnt), 128'd0);
        chk("rst_bit_cnt", 128'(err_bit_cnt), 128'd0);
        chk("rst_lost_lock", 128'(lost_lock), 128'd0);
        do_reset();

        // Clean PRBS stream: lock on the 5th word, no errors afterwards.
        for (int i = 1; i <= 10000; i++) begin
            gen_word(w);
            step(w, 1'b1, 1'b1, i >= 5, 1'b0);
        end
        chk("clean_word_cnt", 128'(err_word_cnt), 128'd0);
        chk("clean_bit_cnt", 128'(err_bit_cnt), 128'd0);

        // Stalled cycle with garbage on the bus changes nothing.
        step({4{32'hDEAD_BEEF}}, 1'b1, 1'b0, 1'b1, 1'b0);

        // Two flipped bits in one word.
        gen_word(w);
        step(w ^ ((128'd1 << 64) | 128'd1), 1'b1, 1'b1, 1'b1, 1'b1);
        gen_word(w);
        step(w, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("flip_word_cnt", 128'(err_word_cnt), 128'd1);
        chk("flip_bit_cnt", 128'(err_bit_cnt), 128'd2);
        chk("flip_lost_lock", 128'(lost_lock), 128'd0);

        // Four zero words drop lock; the clean stream relocks after 5 words.
        bits = 2;
        for (int k = 0; k < 4; k++) begin
            gen_word(w);
            bits += $countones(w);
            step('0, 1'b1, 1'b1, k < 3, 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            gen_word(w);
            step(w, 1'b1, 1'b1, k == 4, 1'b0);
        end
        chk("zero_word_cnt", 128'(err_word_cnt), 128'd5);
        chk("zero_bit_cnt", 128'(err_bit_cnt), 128'(bits));
        chk("zero_lost_lock", 128'(lost_lock), 128'd1);

        // Clear held across an error word and its counter update.
        clr_cnt = 1'b1;
        gen_word(w);
        step(w ^ 128'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        gen_word(w);
        step(w, 1'b1, 1'b1, 1'b1, 1'b0);
        clr_cnt = 1'b0;
        chk("clr_word_cnt", 128'(err_word_cnt), 128'd0);
        chk("clr_bit_cnt", 128'(err_bit_cnt), 128'd0);
        chk("clr_lost_lock", 128'(lost_lock), 128'd0);
        gen_word(w);
        step(w, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_word_cnt_after", 128'(err_word_cnt), 128'd0);
        chk("clr_bit_cnt_after", 128'(err_bit_cnt), 128'd0);

        // Stuck all-ones bus must never lock in PRBS mode.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step('1, 1'b1, 1'b1, 1'b0, 1'b0);
        end

        // Count mode across the 2^128 wrap with valid gaps.
        do_reset();
        cnt_mode = 1'b1;
        c        = '1;
        c        = c - 128'd3;
        nv       = 0;
        for (int i = 0; i < 12; i++) begin
            if ((i % 3) == 1) begin
                step(128'($urandom), 1'b0, 1'b1, nv >= 5, 1'b0);
            end else begin
                nv++;
                step(c, 1'b1, 1'b1, nv >= 5, 1'b0);
                c = c + 128'd1;
            end
        end
        chk("cnt_word_cnt", 128'(err_word_cnt), 128'd0);
        chk("cnt_bit_cnt", 128'(err_bit_cnt), 128'd0);
        cnt_mode = 1'b0;
        step(c, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("mode_lost_lock", 128'(lost_lock), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
